// File: rtl/wb_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_tx_pkg
// Description : Register indices, STATUS bit positions and serializer states
//               for the Wishbone UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_uart_tx_pkg;

    // Word index = addr[3:2]; byte offset = index * 4
    localparam logic [1:0] c_REG_TXDATA = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_DIV    = 2'd2;
    localparam logic [1:0] c_REG_RSVD   = 2'd3;

    localparam int c_STAT_FULL  = 0;
    localparam int c_STAT_EMPTY = 1;
    localparam int c_STAT_BUSY  = 2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_START = c_ST_START,
        ST_DATA  = c_ST_DATA,
        ST_STOP  = c_ST_STOP
    } tx_state_t;

    // Divisors below 2 are kept as written but run the line at 2 clocks/bit
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_tx_if
// Description : Pipelined Wishbone request/response bundle for the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_uart_tx_if;
    logic        i_wb_stb;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_wb_we;
    logic [2:0]  i_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;

    modport slave (
        input  i_wb_stb, i_wb_addr, i_wb_data, i_wb_we, i_wb_sel,
        output o_wb_data, o_wb_ack, o_wb_stall
    );

    modport master (
        output i_wb_stb, i_wb_addr, i_wb_data, i_wb_we, i_wb_sel,
        input  o_wb_data, o_wb_ack, o_wb_stall
    );
endinterface
`default_nettype wire

// File: rtl/wb_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_tx_sync_fifo
// Description : Show-ahead synchronous FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8     // power of 2, >= 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_full;
    logic             r_empty;
    logic [c_CW-1:0]  w_count_next;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
endmodule
`default_nettype wire

// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_tx
// Description : Wishbone-mapped 8N1 UART transmitter with TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    wb_uart_tx_if.slave    bus,
    output logic           o_tx,
    output logic           o_tx_idle
);
    logic [1:0]  w_reg_idx;
    logic        w_stall;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_rdata;
    logic        w_busy;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_baud_done;
    logic        w_unused;

    logic        r_ack;
    logic [31:0] r_rdata;
    logic [15:0] r_div;
    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_baud_cnt;
    logic [15:0] r_frame_div;

    assign w_reg_idx = bus.i_wb_addr[3:2];
    // Stall looks only at the registered full flag, never at a same-cycle pop
    assign w_stall   = bus.i_wb_stb & bus.i_wb_we & (w_reg_idx == c_REG_TXDATA) & w_fifo_full;
    assign w_accept  = bus.i_wb_stb & ~w_stall;
    assign w_push    = w_accept & bus.i_wb_we & (w_reg_idx == c_REG_TXDATA);
    assign w_unused  = &{1'b0, bus.i_wb_addr[31:4], bus.i_wb_addr[1:0],
                         bus.i_wb_data[31:16], bus.i_wb_sel};

    wb_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_push  (w_push),
        .i_data  (bus.i_wb_data[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        w_status               = '0;
        w_status[c_STAT_FULL]  = w_fifo_full;
        w_status[c_STAT_EMPTY] = w_fifo_empty;
        w_status[c_STAT_BUSY]  = w_busy;
        case (w_reg_idx)
            c_REG_STATUS: w_rdata = w_status;
            c_REG_DIV:    w_rdata = {16'd0, r_div};
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_div   <= 16'(CLKS_PER_BIT);
        end else begin
            r_ack   <= w_accept;
            r_rdata <= (w_accept && !bus.i_wb_we) ? w_rdata : '0;
            if (w_accept && bus.i_wb_we && (w_reg_idx == c_REG_DIV)) begin
                r_div <= bus.i_wb_data[15:0];
            end
        end
    end

    assign bus.o_wb_ack   = r_ack;
    assign bus.o_wb_data  = r_rdata;
    assign bus.o_wb_stall = w_stall;

    assign w_baud_done = (r_baud_cnt == r_frame_div - 16'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_baud_done && (r_bit_cnt == 3'd7)) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Chain straight into the next start bit when data is waiting
                if (w_baud_done) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_baud_cnt  <= '0;
            r_frame_div <= 16'd2;
        end else if (w_pop) begin
            r_shift     <= w_fifo_rdata;
            r_bit_cnt   <= '0;
            r_baud_cnt  <= '0;
            r_frame_div <= eff_div(r_div);
        end else if (r_state != ST_IDLE) begin
            if (w_baud_done) begin
                r_baud_cnt <= '0;
                if (r_state == ST_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_START: o_tx = 1'b0;
            ST_DATA:  o_tx = r_shift[0];
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_tx_idle = w_fifo_empty & ~w_busy;
endmodule
`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_uart_tx
// Description : Scoreboard bench for wb_uart_tx: bus acks and serial frames
//               are checked against a behavioural register/line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx;

    typedef struct {
        logic [31:0] data;
        logic        check_data;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic tx_idle;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ack_t   ack_q[$];
    frame_t exp_frames[$];
    int     starts[$];
    int     model_div;

    wb_uart_tx_if bus();

    wb_uart_tx #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .bus       (bus),
        .o_tx      (tx),
        .o_tx_idle (tx_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int line_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus response monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing_ack: no ack at cycle %0d, expected one", ack_q[0].cyc);
                void'(ack_q.pop_front());
            end
            if (bus.o_wb_ack) begin
                if (ack_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_ack: ack at cycle %0d, expected none", cyc);
                end else begin
                    ack_t e;
                    e = ack_q.pop_front();
                    total++;
                    if (cyc != e.cyc || (e.check_data && bus.o_wb_data !== e.data)) begin
                        bad++;
                        $display("FAIL ack: got data %0h at cycle %0d, expected %0h at cycle %0d",
                                 bus.o_wb_data, cyc, e.data, e.cyc);
                    end
                end
            end else if (bus.o_wb_data !== 32'd0) begin
                total++; bad++;
                $display("FAIL data_no_ack: got %0h, expected 0", bus.o_wb_data);
            end
        end
    end

    // Serial line monitor: one frame per falling edge of the idle line
    always begin : serial_mon
        frame_t e;
        logic   ok;
        logic   aborted;
        logic   exp_bit;
        int     b;
        @(negedge clk);
        if (!reset && tx === 1'b0) begin
            starts.push_back(cyc);
            if (exp_frames.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cyc);
                while (tx === 1'b0 && !reset) @(negedge clk);
            end else begin
                e = exp_frames.pop_front();
                ok = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < 10 * e.div; i++) begin
                    if (i > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = i / e.div;
                    if (b == 0)      exp_bit = 1'b0;
                    else if (b == 9) exp_bit = 1'b1;
                    else             exp_bit = e.data[b-1];
                    if (tx !== exp_bit) ok = 1'b0;
                end
                if (!aborted) begin
                    total++;
                    if (!ok) begin
                        bad++;
                        $display("FAIL frame: line waveform wrong, expected byte %0h at %0d clocks/bit",
                                 e.data, e.div);
                    end
                end
            end
        end
    end

    task automatic wb_req(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                          input logic [31:0] exp, output int acc, output logic stalled);
        ack_t a;
        frame_t f;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = {28'h0, idx, 2'b00};
        bus.i_wb_data = wdata;
        bus.i_wb_sel  = 3'($urandom_range(0, 7));
        acc = -1;
        stalled = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!bus.o_wb_stall) begin
                acc = cyc;
                break;
            end
            if (n == 0) stalled = 1'b1;
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL stall_timeout: request still stalled, expected acceptance");
        end else begin
            a.data = exp;
            a.check_data = ~we;
            a.cyc = acc + 1;
            ack_q.push_back(a);
            if (we && idx == 2'd0) begin
                f.data = wdata[7:0];
                f.div  = line_div(model_div);
                exp_frames.push_back(f);
            end
            if (we && idx == 2'd2) model_div = int'(wdata[15:0]);
        end
        @(posedge clk); #1;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] wdata);
        int acc;
        logic st;
        wb_req(1'b1, idx, wdata, 32'd0, acc, st);
    endtask

    task automatic wb_read(input logic [1:0] idx, input logic [31:0] exp);
        int acc;
        logic st;
        wb_req(1'b0, idx, 32'd0, exp, acc, st);
    endtask

    task automatic wait_idle(input int limit, output int c);
        c = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (tx_idle) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            total++; bad++;
            $display("FAIL idle_timeout: o_tx_idle low, expected high within %0d clocks", limit);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   ic;
        int   acc;
        logic st;
        int   n;

        reset = 1'b1;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = '0;
        bus.i_wb_data = '0;
        bus.i_wb_sel  = '0;
        model_div = 16;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ack", {31'd0, bus.o_wb_ack}, 32'd0);
        chk("reset_idle", {31'd0, tx_idle}, 32'd1);
        reset = 1'b0;
        wb_read(2'd1, 32'h2);
        wb_read(2'd2, 32'd16);

        // Single frame at 4 clocks/bit
        wb_write(2'd2, 32'd4);
        starts.delete();
        wb_write(2'd0, 32'hA5);
        wait_idle(200, ic);
        chk("frame_count_a5", starts.size(), 32'd1);
        if (starts.size() > 0) chk("idle_after_40", ic - starts[0], 32'd40);

        // Read-only / reserved writes ignored; back-to-back reads
        wb_write(2'd1, 32'hFFFF);
        wb_write(2'd3, 32'h1234);
        wb_read(2'd3, 32'd0);
        wb_read(2'd0, 32'd0);
        wb_read(2'd1, 32'h2);
        wb_read(2'd2, 32'd4);
        wb_read(2'd1, 32'h2);
        wb_read(2'd2, 32'd4);

        // Overflow: FIFO fills, tenth write waits for the first frame to finish
        wb_write(2'd2, 32'd100);
        starts.delete();
        for (int i = 0; i < 9; i++) wb_write(2'd0, 32'($urandom_range(0, 255)));
        wb_read(2'd1, 32'h5);
        wb_req(1'b1, 2'd0, 32'h3C, 32'd0, acc, st);
        chk("overflow_stalled", {31'd0, st}, 32'd1);
        if (starts.size() > 0) chk("overflow_accept", acc - starts[0], 32'd1000);
        else chk("overflow_accept", 32'hFFFF_FFFF, 32'd1000);
        wait_idle(12000, ic);
        chk("overflow_frames", starts.size(), 32'd10);

        // Back-to-back frames with no gap
        wb_write(2'd2, 32'd2);
        starts.delete();
        wb_write(2'd0, 32'h00);
        wb_write(2'd0, 32'hFF);
        wait_idle(200, ic);
        chk("b2b_frames", starts.size(), 32'd2);
        if (starts.size() == 2) chk("b2b_no_gap", starts[1] - starts[0], 32'd20);

        // Randomized bursts with random divisors, including 0 and 1
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 5);
            wb_write(2'd2, 32'(n));
            wb_read(2'd2, 32'(n));
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) wb_read(2'd2, 32'(model_div));
                wb_write(2'd0, 32'($urandom_range(0, 255)));
            end
            wait_idle(2000, ic);
        end

        // Reset in the middle of a frame's data bits
        wb_write(2'd2, 32'd4);
        starts.delete();
        wb_write(2'd0, 32'h00);
        for (int i = 0; i < 3; i++) wb_write(2'd0, 32'($urandom_range(0, 255)));
        for (int i = 0; i < 100 && starts.size() == 0; i++) @(negedge clk);
        chk("mid_frame_started", starts.size(), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_frame_data_low", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        ack_q.delete();
        exp_frames.delete();
        model_div = 16;
        @(posedge clk); #1;
        chk("mid_reset_tx", {31'd0, tx}, 32'd1);
        chk("mid_reset_ack", {31'd0, bus.o_wb_ack}, 32'd0);
        chk("mid_reset_idle", {31'd0, tx_idle}, 32'd1);
        reset = 1'b0;
        wb_read(2'd1, 32'h2);
        repeat (200) @(posedge clk);
        chk("no_frames_after_reset", starts.size(), 32'd1);

        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("frame_queue_drained", exp_frames.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
